mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
//
// PURPOSE
// Iterative MIPS multiply/divide unit holding the HI/LO registers. Sits directly
// downstream of register_file: op_a/op_b are driven from read_data_a/read_data_b.
// Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
// hi/lo feed the writeback mux for MFHI/MFLO; busy drives the hazard/stall logic.
//
// PARAMETERS
// DATA_W  32  operand/HI/LO width; iteration count = DATA_W
//
// PORTS
// clk    in   1       rising-edge clock
// reset  in   1       asynchronous, active-low reset
// start  in   1       request; sampled on rising clk edge, accepted only when busy=0
// op     in   3       0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6/7 reserved (no-op)
// op_a   in   DATA_W  rs operand (multiplicand / dividend / MTHI/MTLO data)
// op_b   in   DATA_W  rt operand (multiplier / divisor)
// busy   out  1       1 while an arithmetic op is in flight
// done   out  1       one-cycle pulse: HI/LO just updated by an arithmetic op
// hi     out  DATA_W  HI register
// lo     out  DATA_W  LO register
//
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0; any op aborted.
// - FSM: IDLE -> CALC (DATA_W cycles) -> FINISH (1 cycle) -> IDLE. busy=(state!=IDLE).
// - Accept: start=1 & busy=0 at edge N. Arithmetic op: latch magnitudes, signs, op;
//   enter CALC. hi/lo written at edge N+DATA_W+1; done=1 and busy=0 in the cycle
//   after that edge. Back-to-back start accepted in the done cycle.
// - start while busy=1: ignored, no effect on state, hi/lo or done.
// - MTHI/MTLO accepted (busy=0): hi (resp. lo) <= op_a at edge N; busy, done stay 0.
// - Reserved op codes: ignored.
// - Multiply: shift-add on magnitudes, 2*DATA_W-bit product; {hi,lo}=product.
//   MULT: operands sign-magnitude converted, product negated if signs differ.
// - Divide: restoring, one quotient bit per CALC cycle on magnitudes.
//   lo=quotient, hi=remainder. DIV: quotient negated if signs differ; remainder
//   takes dividend's sign. 0x80000000/-1 -> lo=0x80000000, hi=0 (no trap).
// - Divide by zero: full latency, done pulses, hi/lo unchanged.
// - Operands held internally after accept; op_a/op_b may change while busy.
// - No arithmetic flags, no exceptions; all arithmetic modulo 2^DATA_W per half.
//
// TESTING
// 1. MULT 7*6 -> 33 cycles later done=1, lo=0x0000002A, hi=0; busy high 33 cycles.
// 2. MULT 0xFFFFFFFF*1 -> hi=lo=0xFFFFFFFF; MULTU 0xFFFFFFFF*0xFFFFFFFF ->
//    hi=0xFFFFFFFE, lo=0x00000001.
// 3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2;
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
// 4. MTHI 0x12345678 then MTLO 0x9ABCDEF0, then DIVU x/0 -> done after 33 cycles,
//    hi=0x12345678, lo=0x9ABCDEF0 unchanged.
// 5. Start MULT, issue MTLO 0xDEAD and second MULT while busy -> both ignored;
//    result matches first MULT only; back-to-back MULT in done cycle accepted.
// 6. Assert reset at CALC cycle 10 -> busy=0, done=0, hi=lo=0 immediately (async);
//    no done pulse after release; next op completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, sign fix-up applied when HI/LO are written.
module mult_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   // state    | meaning
   // S_IDLE   | waiting for start; MTHI/MTLO complete here in one cycle
   // S_CALC   | DATA_W iterations, one product/quotient bit per cycle
   // S_FINISH | sign fix-up, HI/LO written, done pulses in the following cycle
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  is_div_q, is_div_d;
   logic                  neg_q, neg_d;
   logic                  rem_neg_q, rem_neg_d;
   logic [DATA_W-1:0]     b_mag_q, b_mag_d;
   logic [2*DATA_W-1:0]   p_q, p_d;
   logic [DATA_W-1:0]     hi_q, hi_d;
   logic [DATA_W-1:0]     lo_q, lo_d;
   logic                  done_q, done_d;

   logic                  is_signed;
   logic                  a_neg, b_neg;
   logic [DATA_W-1:0]     a_mag, b_mag;
   logic [DATA_W:0]       mul_sum;
   logic [2*DATA_W-1:0]   mul_next;
   logic [DATA_W:0]       r_sh, div_diff;
   logic [2*DATA_W-1:0]   div_next;
   logic [2*DATA_W-1:0]   prod_signed;

   always_comb begin
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = is_signed & op_a[DATA_W-1];
      b_neg     = is_signed & op_b[DATA_W-1];
      a_mag     = a_neg ? -op_a : op_a;
      b_mag     = b_neg ? -op_b : op_b;

      // p_q = {partial product, remaining multiplier bits}
      mul_sum  = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, b_mag_q} : '0);
      mul_next = {mul_sum, p_q[DATA_W-1:1]};

      // p_q = {partial remainder, dividend bits shifting out / quotient bits shifting in}
      r_sh     = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
      div_diff = r_sh - {1'b0, b_mag_q};
      if (!div_diff[DATA_W])
         div_next = {div_diff[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
      else
         div_next = {r_sh[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0};

      prod_signed = neg_q ? -p_q : p_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      b_mag_d   = b_mag_q;
      p_d       = p_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d   = S_CALC;
                     cnt_d     = CNT_INIT;
                     is_div_d  = op[1];
                     neg_d     = a_neg ^ b_neg;
                     rem_neg_d = a_neg;
                     b_mag_d   = b_mag;
                     p_d       = {{DATA_W{1'b0}}, a_mag};
                  end
                  OP_MTHI: hi_d = op_a;
                  OP_MTLO: lo_d = op_a;
                  default: ;
               endcase
            end
         end
         S_CALC: begin
            p_d = is_div_q ? div_next : mul_next;
            if (cnt_q == '0)
               state_d = S_FINISH;
            else
               cnt_d = cnt_q - 1'b1;
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = prod_signed[2*DATA_W-1:DATA_W];
               lo_d = prod_signed[DATA_W-1:0];
            end else if (b_mag_q != '0) begin
               lo_d = neg_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
               hi_d = rem_neg_q ? -p_q[2*DATA_W-1:DATA_W] : p_q[2*DATA_W-1:DATA_W];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         b_mag_q   <= '0;
         p_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         b_mag_q   <= b_mag_d;
         p_q       <= p_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops checked against
// an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int n_pass = 0;
   int n_total = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   mult_div_unit #(.DATA_W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint      q, r;
      logic [63:0] pv;
      case (o)
         3'd0: begin
            pv = 64'(longint'($signed(a)) * longint'($signed(b)));
            m_hi = pv[63:32]; m_lo = pv[31:0];
         end
         3'd1: begin
            pv = {32'b0, a} * {32'b0, b};
            m_hi = pv[63:32]; m_lo = pv[31:0];
         end
         3'd2: if (b != 0) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[31:0]; m_hi = r[31:0];
         end
         3'd3: if (b != 0) begin
            m_lo = a / b; m_hi = a % b;
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else n_pass++;
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; op = o; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0; op_a = $urandom; op_b = $urandom;
   endtask

   // called at the negedge after the accepting edge
   task automatic wait_done(output int cyc, output int bcnt);
      cyc = 0; bcnt = 0;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_arith(input string name, input logic [2:0] o,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      int cyc, bcnt;
      issue(o, a, b);
      model(o, a, b);
      wait_done(cyc, bcnt);
      check({name, " latency"}, W'(cyc), W'(W + 1));
      check({name, " busy_cycles"}, W'(bcnt), W'(W + 1));
      check({name, " busy_at_done"}, W'(busy), '0);
      check({name, " hi"}, hi, m_hi);
      check({name, " lo"}, lo, m_lo);
      @(negedge clk);
      check({name, " done_pulse"}, W'(done), '0);
   endtask

   task automatic test_reset;
      #2;
      check("reset busy", W'(busy), '0);
      check("reset done", W'(done), '0);
      check("reset hi", hi, '0);
      check("reset lo", lo, '0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_directed;
      run_arith("mult_7x6", 3'd0, 32'd7, 32'd6);
      run_arith("mult_m1x1", 3'd0, 32'hFFFF_FFFF, 32'd1);
      check("mult_m1x1 hi_const", hi, 32'hFFFF_FFFF);
      run_arith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max hi_const", hi, 32'hFFFF_FFFE);
      check("multu_max lo_const", lo, 32'h0000_0001);
      run_arith("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
      check("div_m7_2 lo_const", lo, 32'hFFFF_FFFD);
      run_arith("divu_100_7", 3'd3, 32'd100, 32'd7);
      check("divu_100_7 lo_const", lo, 32'd14);
      run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf lo_const", lo, 32'h8000_0000);
      check("div_ovf hi_const", hi, 32'h0);
   endtask

   task automatic test_div_zero;
      issue(3'd4, 32'h1234_5678, 32'h0);
      model(3'd4, 32'h1234_5678, 32'h0);
      check("mthi busy", W'(busy), '0);
      check("mthi hi", hi, 32'h1234_5678);
      issue(3'd5, 32'h9ABC_DEF0, 32'h0);
      model(3'd5, 32'h9ABC_DEF0, 32'h0);
      check("mtlo done", W'(done), '0);
      check("mtlo lo", lo, 32'h9ABC_DEF0);
      run_arith("divu_by0", 3'd3, 32'd55, 32'd0);
      check("divu_by0 hi_const", hi, 32'h1234_5678);
      check("divu_by0 lo_const", lo, 32'h9ABC_DEF0);
   endtask

   task automatic test_back_to_back;
      int cyc, bcnt;
      issue(3'd0, 32'd1000, 32'hFFFF_FFFD);
      model(3'd0, 32'd1000, 32'hFFFF_FFFD);
      start = 1'b1; op = 3'd5; op_a = 32'h0000_DEAD;
      @(negedge clk);
      op = 3'd0; op_a = 32'd3; op_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bcnt);
      check("ignore done_seen", W'(done), 32'd1);
      check("ignore hi", hi, m_hi);
      check("ignore lo", lo, m_lo);
      start = 1'b1; op = 3'd1; op_a = 32'h0001_0001; op_b = 32'h0000_FFFF;
      @(negedge clk);
      start = 1'b0;
      model(3'd1, 32'h0001_0001, 32'h0000_FFFF);
      check("b2b busy", W'(busy), 32'd1);
      wait_done(cyc, bcnt);
      check("b2b latency", W'(cyc), W'(W + 1));
      check("b2b hi", hi, m_hi);
      check("b2b lo", lo, m_lo);
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      logic seen;
      issue(3'd0, 32'd12345, 32'd678);
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      check("areset busy", W'(busy), '0);
      check("areset done", W'(done), '0);
      check("areset hi", hi, '0);
      check("areset lo", lo, '0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("areset no_done", W'(seen), '0);
      run_arith("post_reset", 3'd2, 32'hFFFF_FF9C, 32'd7);
   endtask

   task automatic test_random;
      logic [2:0]   o;
      logic [W-1:0] a, b;
      for (int i = 0; i < 30; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = W'($urandom_range(1, 20));
            2: a = W'($urandom_range(0, 300));
            default: ;
         endcase
         if (o <= 3'd3) begin
            run_arith($sformatf("rand%0d_op%0d", i, o), o, a, b);
         end else begin
            issue(o, a, b);
            model(o, a, b);
            check($sformatf("rand%0d_op%0d busy", i, o), W'(busy), '0);
            check($sformatf("rand%0d_op%0d done", i, o), W'(done), '0);
            check($sformatf("rand%0d_op%0d hi", i, o), hi, m_hi);
            check($sformatf("rand%0d_op%0d lo", i, o), lo, m_lo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
